// File: rtl/mips_avalon_master.sv
// Bus interface unit: arbitrates MIPS fetch and data requests onto one Avalon-MM
// master port, returns read data with a one-cycle done pulse, and aborts stalled transfers.
module mips_avalon_master #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_data_q, is_data_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        bus_error_q, bus_error_d;

    logic accept_data, accept_fetch, zero_store, bus_ack, wd_abort;

    // Requests are levels sampled only in IDLE; done pulses for exactly the RESP
    // cycle, and the requester must have dropped req by the following IDLE edge.
    assign accept_data  = (state_q == IDLE) && d_req;
    assign accept_fetch = (state_q == IDLE) && !d_req && i_req;
    assign zero_store   = d_we && (d_be == 4'b0000);
    assign bus_ack      = (state_q == BUS) && !waitrequest;
    assign wd_abort     = WD_EN && (state_q == BUS) && waitrequest && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_data) begin
                    state_d = zero_store ? RESP : BUS;
                end else if (accept_fetch) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus_ack || wd_abort) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_done = (state_q == RESP) && !is_data_q;
        d_done = (state_q == RESP) && is_data_q;
    end

    always_comb begin
        is_data_d    = is_data_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        wd_cnt_d     = wd_cnt_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        bus_error_d  = bus_error_q;
        if (accept_data) begin
            is_data_d    = 1'b1;
            address_d    = {d_addr[31:2], 2'b00};
            byteenable_d = d_be;
            read_d       = !d_we;
            write_d      = !zero_store && d_we;
            wd_cnt_d     = 32'd0;
            if (d_we) begin
                writedata_d = d_wdata;
            end
        end else if (accept_fetch) begin
            is_data_d    = 1'b0;
            address_d    = {i_addr[31:2], 2'b00};
            byteenable_d = 4'b1111;
            read_d       = 1'b1;
            write_d      = 1'b0;
            wd_cnt_d     = 32'd0;
        end else if (state_q == BUS) begin
            if (!waitrequest || wd_abort) begin
                read_d  = 1'b0;
                write_d = 1'b0;
                if (read_q) begin
                    if (is_data_q) begin
                        d_rdata_d = waitrequest ? ERR_DATA : readdata;
                    end else begin
                        i_rdata_d = waitrequest ? ERR_DATA : readdata;
                    end
                end
                if (wd_abort) begin
                    bus_error_d = 1'b1;
                end
            end else begin
                wd_cnt_d = wd_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_data_q    <= 1'b0;
            address_q    <= 32'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'd0;
            wd_cnt_q     <= 32'd0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            bus_error_q  <= 1'b0;
        end else begin
            is_data_q    <= is_data_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            wd_cnt_q     <= wd_cnt_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign bus_error  = bus_error_q;

endmodule
